// File: rtl/one_wire_pkg.sv
// Shared 1-Wire definitions: default bus timing in microseconds, the master
// transmitter state encoding and the default phase counter width.
package one_wire_pkg;

    localparam int OW_CLK_PER_US = 100;
    localparam int OW_T_RSTL_US  = 480;
    localparam int OW_T_RSTH_US  = 100;
    localparam int OW_T_PDS_US   = 70;
    localparam int OW_T_LOW1_US  = 6;
    localparam int OW_T_SLOT_US  = 60;
    localparam int OW_T_REC_US   = 2;

    // The reset pulse is the longest phase, so it sizes the phase counter.
    localparam int OW_CNT_W = $clog2(OW_T_RSTL_US * OW_CLK_PER_US + 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_REL,
        BIT_LOW,
        BIT_REL,
        RECOVER
    } ow_tx_state_t;

endpackage

// File: rtl/one_wire_sync.sv
// Two-flop synchronizer for the asynchronous 1-Wire bus level; resets to the
// released (high) bus level so no false presence is seen out of reset.
module one_wire_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/one_wire_master_tx.sv
// 1-Wire master transmitter: issues reset/presence sequences or MSB-first
// byte writes on an open-drain bus, one command per valid/ready handshake.
module one_wire_master_tx
    import one_wire_pkg::*;
#(
    parameter int CLK_PER_US = OW_CLK_PER_US,
    parameter int T_RSTL_US  = OW_T_RSTL_US,
    parameter int T_RSTH_US  = OW_T_RSTH_US,
    parameter int T_PDS_US   = OW_T_PDS_US,
    parameter int T_LOW1_US  = OW_T_LOW1_US,
    parameter int T_SLOT_US  = OW_T_SLOT_US,
    parameter int T_REC_US   = OW_T_REC_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_reset,
    input  logic [7:0] cmd_byte,
    inout  wire        one_wire_data,
    output logic       busy,
    output logic       done,
    output logic       presence
);

    localparam int T_RSTL = T_RSTL_US * CLK_PER_US;
    localparam int T_RSTH = T_RSTH_US * CLK_PER_US;
    localparam int T_PDS  = T_PDS_US  * CLK_PER_US;
    localparam int T_LOW1 = T_LOW1_US * CLK_PER_US;
    localparam int T_SLOT = T_SLOT_US * CLK_PER_US;
    localparam int T_REC  = T_REC_US  * CLK_PER_US;
    localparam int CNT_W  = $clog2(T_RSTL + 1);
    // Down-counter value during the cycle that ends T_PDS cycles after release.
    localparam int PDS_CNT = T_RSTH - T_PDS + 1;

    ow_tx_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic             drive_low_reg, drive_low_next;
    logic             done_reg, done_next;
    logic             presence_reg, presence_next;
    logic             bus_sync;
    logic             last_cycle;

    one_wire_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (one_wire_data),
        .q   (bus_sync)
    );

    assign busy      = (state_reg != IDLE);
    assign cmd_ready = enable && !busy && !rst;
    assign done      = done_reg;
    assign presence  = presence_reg;
    assign last_cycle = (cnt_reg == CNT_W'(1));

    // Drive is registered so the pad never sees decode glitches of the state.
    assign one_wire_data = drive_low_reg ? 1'b0 : 1'bz;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        done_next     = 1'b0;
        presence_next = presence_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_reset) begin
                        state_next = RST_LOW;
                        cnt_next   = CNT_W'(T_RSTL);
                    end else begin
                        state_next   = BIT_LOW;
                        shift_next   = cmd_byte;
                        bit_cnt_next = 3'd7;
                        cnt_next     = cmd_byte[7] ? CNT_W'(T_LOW1) : CNT_W'(T_SLOT);
                    end
                end
            end
            RST_LOW: begin
                if (last_cycle) begin
                    state_next = RST_REL;
                    cnt_next   = CNT_W'(T_RSTH);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RST_REL: begin
                if (cnt_reg == CNT_W'(PDS_CNT)) begin
                    presence_next = !bus_sync;
                end
                if (last_cycle) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            BIT_LOW: begin
                if (last_cycle) begin
                    // A write-0 slot is low for the whole slot, so it skips BIT_REL.
                    if (shift_reg[7]) begin
                        state_next = BIT_REL;
                        cnt_next   = CNT_W'(T_SLOT - T_LOW1);
                    end else begin
                        state_next = RECOVER;
                        cnt_next   = CNT_W'(T_REC);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            BIT_REL: begin
                if (last_cycle) begin
                    state_next = RECOVER;
                    cnt_next   = CNT_W'(T_REC);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (last_cycle) begin
                    if (bit_cnt_reg == 3'd0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next   = BIT_LOW;
                        bit_cnt_next = bit_cnt_reg - 3'd1;
                        shift_next   = {shift_reg[6:0], 1'b0};
                        cnt_next     = shift_reg[6] ? CNT_W'(T_LOW1) : CNT_W'(T_SLOT);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Losing enable aborts silently: bus released, no completion, presence kept.
        if (!enable) begin
            state_next    = IDLE;
            done_next     = 1'b0;
            presence_next = presence_reg;
        end

        drive_low_next = (state_next == RST_LOW) || (state_next == BIT_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            drive_low_reg <= 1'b0;
            done_reg      <= 1'b0;
            presence_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            drive_low_reg <= drive_low_next;
            done_reg      <= done_next;
            presence_reg  <= presence_next;
        end
    end

endmodule

// File: tb/tb_one_wire_master_tx.sv
// Directed/randomized bench for one_wire_master_tx with a bus monitor that
// measures low pulses and a behavioural slave that answers reset pulses.
module tb_one_wire_master_tx;

    localparam int CLK  = 2;
    localparam int RSTL = 480 * CLK;
    localparam int RSTH = 100 * CLK;
    localparam int LOW1 = 6 * CLK;
    localparam int SLOT = 60 * CLK;
    localparam int REC  = 2 * CLK;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_reset = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_ready, busy, done, presence;
    wire        one_wire_data;
    logic       slave_low = 1'b0;

    pullup (one_wire_data);
    assign one_wire_data = slave_low ? 1'b0 : 1'bz;

    one_wire_master_tx #(
        .CLK_PER_US (CLK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_reset     (cmd_reset),
        .cmd_byte      (cmd_byte),
        .one_wire_data (one_wire_data),
        .busy          (busy),
        .done          (done),
        .presence      (presence)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int starts[$];
    int widths[$];
    int low_start = 0;
    logic prev_bus = 1'b1;
    bit slave_en = 1'b0;
    int rel_cyc = -1000000;
    int done_count = 0;

    // Monitor plus slave: the slave pulls low 15..240 us after a long low ends.
    always @(negedge clk) begin
        logic b;
        b = one_wire_data;
        if (prev_bus && !b) begin
            starts.push_back(cyc);
            low_start = cyc;
        end
        if (!prev_bus && b) begin
            widths.push_back(cyc - low_start);
            if (cyc - low_start >= RSTL * 3 / 4) rel_cyc = cyc;
        end
        prev_bus = b;
        slave_low = slave_en && (cyc - rel_cyc >= 15 * CLK) && (cyc - rel_cyc < 240 * CLK);
        if (done) done_count++;
    end

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input bit is_rst, input logic [7:0] b, input bit hold, output int hs);
        @(negedge clk);
        starts.delete();
        widths.delete();
        cmd_valid = 1'b1;
        cmd_reset = is_rst;
        cmd_byte  = b;
        chk("ready_before_handshake", int'(cmd_ready), 1);
        @(negedge clk);
        hs = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int hs, input int budget, output int lat);
        bit ready_busy;
        ready_busy = 1'b0;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                lat = cyc - hs;
                break;
            end
            if (busy && cmd_ready) ready_busy = 1'b1;
            @(negedge clk);
        end
        chk("ready_low_while_busy", int'(ready_busy), 0);
    endtask

    // Reference: MSB first, 1 -> short low, 0 -> full-slot low, slots SLOT+REC apart.
    task automatic check_byte(input string tag, input logic [7:0] b, input int hs, input int lat);
        logic [7:0] v;
        v = b;
        chk($sformatf("%s_latency", tag), lat, 8 * (SLOT + REC));
        chk($sformatf("%s_pulse_count", tag), widths.size(), 8);
        if (widths.size() == 8 && starts.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s_b%0d_low_width", tag, 7 - i), widths[i], v[7-i] ? LOW1 : SLOT);
                chk($sformatf("%s_b%0d_start", tag, 7 - i), starts[i] - hs, i * (SLOT + REC));
            end
        end
        chk($sformatf("%s_busy_at_done", tag), int'(busy), 0);
    endtask

    initial begin
        int hs, hs2, lat, dc, d;
        logic [7:0] rb;

        enable = 1'b1;
        repeat (3) tick();
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_presence", int'(presence), 0);
        chk("reset_bus", int'(one_wire_data), 1);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(cmd_ready), 1);
        enable = 1'b0;
        #1;
        chk("ready_enable_low", int'(cmd_ready), 0);
        enable = 1'b1;

        // Reset command answered by a slave.
        slave_en = 1'b1;
        send(1'b1, 8'h00, 1'b0, hs);
        wait_done(hs, 3000, lat);
        chk("rst_slave_latency", lat, RSTL + RSTH);
        chk("rst_slave_low_width", widths.size() > 0 ? widths[0] : -1, RSTL);
        chk("rst_slave_start", starts.size() > 0 ? starts[0] - hs : -1, 0);
        chk("rst_slave_presence", int'(presence), 1);
        chk("rst_slave_busy_at_done", int'(busy), 0);
        repeat (300) tick();

        // Enable dropped mid reset pulse.
        send(1'b1, 8'h00, 1'b0, hs);
        repeat (300) tick();
        dc = done_count;
        enable = 1'b0;
        tick();
        chk("abort_en_bus", int'(one_wire_data), 1);
        chk("abort_en_busy", int'(busy), 0);
        enable = 1'b1;
        repeat (RSTL + RSTH) tick();
        chk("abort_en_no_done", done_count - dc, 0);
        chk("abort_en_presence_kept", int'(presence), 1);
        slave_en = 1'b0;

        // rst pulsed during bit 3 of 0xFF.
        send(1'b0, 8'hFF, 1'b0, hs);
        for (int i = 0; i < 5000 && starts.size() < 5; i++) tick();
        chk("rst_mid_reached_bit3", starts.size(), 5);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_bus", int'(one_wire_data), 1);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_presence", int'(presence), 0);
        rst = 1'b0;
        tick();
        rb = 8'($urandom);
        send(1'b0, rb, 1'b0, hs);
        wait_done(hs, 3000, lat);
        check_byte($sformatf("after_rst_%02h", rb), rb, hs, lat);

        // cmd_reset has priority over the byte field; no slave present.
        send(1'b1, 8'hFF, 1'b0, hs);
        wait_done(hs, 3000, lat);
        chk("rst_prio_latency", lat, RSTL + RSTH);
        chk("rst_prio_pulse_count", widths.size(), 1);
        chk("rst_prio_low_width", widths.size() > 0 ? widths[0] : -1, RSTL);
        chk("rst_noslave_presence", int'(presence), 0);

        send(1'b0, 8'hA5, 1'b0, hs);
        wait_done(hs, 3000, lat);
        check_byte("byte_a5", 8'hA5, hs, lat);

        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            send(1'b0, rb, 1'b0, hs);
            wait_done(hs, 3000, lat);
            check_byte($sformatf("rand%0d_%02h", k, rb), rb, hs, lat);
        end

        // Back-to-back: valid held, second byte 0x3C accepted only in the done cycle.
        rb = 8'($urandom);
        send(1'b0, rb, 1'b1, hs);
        cmd_byte = 8'h3C;
        wait_done(hs, 3000, lat);
        chk("b2b_ready_in_done", int'(cmd_ready), 1);
        check_byte($sformatf("b2b_first_%02h", rb), rb, hs, lat);
        d = cyc;
        starts.delete();
        widths.delete();
        tick();
        cmd_valid = 1'b0;
        hs2 = cyc;
        chk("b2b_second_hs_cycle", hs2 - d, 1);
        wait_done(hs2, 3000, lat);
        check_byte("b2b_3c", 8'h3C, hs2, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
